alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the combinational ALU.
- Accepts operand pairs A/B and a 6-bit MIPS-style function code over a valid/ready handshake.
- Computes the result through a configurable number of register stages and returns it with status flags.
- Sits between the operand-loading front end (switches/buttons or a later UART receiver) and the display/transmit back end.

Parameters:
N_BITS, 8, operand and result width (>=4)
N_OP, 6, function code width
PIPE_STAGES, 2, register stages from acceptance to output (1..4)

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_A  input  N_BITS  operand A
i_B  input  N_BITS  operand B (also the shift amount)
i_Op  input  N_OP  function code
i_valid  input  1  operand set present
o_ready  output  1  block can accept this cycle
o_res  output  N_BITS  result
o_zero  output  1  result == 0
o_neg  output  1  result MSB
o_carry  output  1  ADD carry-out; SUB borrow (A<B unsigned); 0 otherwise
o_ovf  output  1  signed overflow on ADD/SUB; 0 otherwise
o_err  output  1  unsupported function code
o_valid  output  1  output bundle valid
i_ready  input  1  downstream accepts output

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_reset is asynchronous and active-high.
- Reset: all stage valid bits, o_valid, o_res, and all flags go to 0. Reset mid-operation flushes every in-flight op; nothing is emitted after release.
- Acceptance: an op is accepted on a rising edge with i_valid && o_ready.
- Combinational ready: o_ready = !(o_valid && !i_ready). It has no combinational path from i_valid.
- Stall: when o_valid && !i_ready, every stage holds, including its valid bit and data. o_res and the flags stay stable until accepted.
- No stall: stages advance every cycle. Bubbles (valid=0) propagate, and no data is lost or duplicated. Order is strictly preserved.
- Latency: an op accepted at edge k appears with o_valid=1 after edge k+PIPE_STAGES, absent stalls.
- Throughput: one op per cycle.
- Compute location: the operation is computed combinationally from stage-0 registered operands. Remaining stages are pure delay.
- Function codes:
  - ADD 100000: A+B
  - SUB 100010: A-B
  - AND 100100
  - OR 100101
  - XOR 100110
  - NOR 100111: ~(A|B)
  - SRL 000010: logical right shift
  - SRA 000011: arithmetic right shift
  - SLL 000000: left shift
  - SLT 101010: 1 if signed A<B, else 0
- Shift amount: B[$clog2(N_BITS)-1:0]. Upper bits of B are ignored, e.g. N_BITS=8, B=9 shifts by 1.
- Width: all arithmetic is modulo 2^N_BITS. Carry uses an N_BITS+1 internal sum.
- ovf definition: set when the operand signs match (ADD) or differ (SUB) and the result sign differs from A.
- Unsupported code: o_res=0, o_err=1, o_zero=1, other flags 0.
- o_zero and o_neg are derived from the final o_res, including after saturation when it is enabled.
- Simultaneous i_valid with output acceptance in the same cycle is legal and keeps full rate.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined: ADD/SUB saturate on signed overflow to 2^(N_BITS-1)-1 (positive overflow) or -2^(N_BITS-1) (negative overflow). o_ovf is still 1, and o_carry is unchanged.
- Undefined: results wrap modulo 2^N_BITS and no saturation logic exists.

Test Plan:
- Arithmetic and logic (N_BITS=8, PIPE_STAGES=2, i_ready=1):
  - ADD A=3, B=3 -> o_res=0x06 two cycles after acceptance, all flags 0.
  - SUB 6-2 -> 0x04.
  - SUB 2-6 -> 0xFC, carry=1, neg=1, ovf=0.
- Overflow and zero:
  - ADD 0x7F+0x01 -> 0x80, ovf=1, neg=1 (0x7F with ALU_PIPE_SAT_EN).
  - ADD 0xFF+0x01 -> 0x00, carry=1, zero=1.
- Shifts, logic, compare and error:
  - SRA 0x8F, B=1 -> 0xC7.
  - SRL 0x10, B=2 -> 0x04.
  - SLL 0x01, B=9 -> 0x02.
  - NOR 0x0F, 0x04 -> 0xF0.
  - SLT 0xFE, 0x01 -> 0x01.
  - Op 111111 -> o_res=0, err=1.
- Back-to-back with backpressure: ops ADD 1+1, ADD 2+2, ADD 3+3 on consecutive cycles, with i_ready=0 for 3 cycles once o_valid rises.
  - Required: o_ready=0 while stalled, o_res holds 0x02.
  - After i_ready=1: 0x02, 0x04, 0x06 on consecutive cycles, no loss or duplication.
- Reset mid-flight: assert i_reset asynchronously between edges with 2 ops in flight.
  - Required: outputs 0 immediately.
  - After release, o_valid stays 0 until a new op completes.
- Bubbles: i_valid pattern 1,0,1 -> o_valid pattern 1,0,1 delayed by PIPE_STAGES cycles. Repeat for PIPE_STAGES=1 and 4.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined ALU: MIPS-style function codes over a valid/ready handshake.
// Define ALU_PIPE_SAT_EN to saturate ADD/SUB results on signed overflow.
module alu_pipe #(
    parameter int unsigned N_BITS      = 8,
    parameter int unsigned N_OP        = 6,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_BITS-1:0] i_A,
    input  logic [N_BITS-1:0] i_B,
    input  logic [N_OP-1:0]   i_Op,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [N_BITS-1:0] o_res,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_carry,
    output logic              o_ovf,
    output logic              o_err,
    output logic              o_valid,
    input  logic              i_ready
);

    localparam int unsigned SH_W = $clog2(N_BITS);
    localparam int unsigned BW   = N_BITS + 5;
    localparam int unsigned MSB  = N_BITS - 1;

    localparam logic [N_OP-1:0] OP_SLL = N_OP'(6'b000000);
    localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);
    localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
    localparam logic [N_OP-1:0] OP_SLT = N_OP'(6'b101010);

`ifdef ALU_PIPE_SAT_EN
    localparam logic [N_BITS-1:0] SAT_MAX = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic [N_BITS-1:0] SAT_MIN = {1'b1, {(N_BITS-1){1'b0}}};
`endif

    logic              advance;
    logic              s0_valid;
    logic [N_BITS-1:0] a_q;
    logic [N_BITS-1:0] b_q;
    logic [N_OP-1:0]   op_q;

    logic [SH_W-1:0]   shamt;
    logic [N_BITS:0]   sum;
    logic [N_BITS-1:0] diff;
    logic [N_BITS-1:0] res;
    logic              zero;
    logic              neg;
    logic              carry;
    logic              ovf;
    logic              err;

    logic [PIPE_STAGES-1:0] v_q;
    logic [BW-1:0]          d_q [PIPE_STAGES];

    // Whole pipeline freezes only when the output is held by the consumer.
    assign o_ready = !(o_valid && !i_ready);
    assign advance = o_ready;

    always_comb begin
        shamt = b_q[SH_W-1:0];
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = a_q - b_q;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res   = sum[N_BITS-1:0];
                carry = sum[N_BITS];
                ovf   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res   = diff;
                carry = (a_q < b_q);
                ovf   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_NOR: res = ~(a_q | b_q);
            OP_SRL: res = a_q >> shamt;
            OP_SRA: res = $unsigned($signed(a_q) >>> shamt);
            OP_SLL: res = a_q << shamt;
            OP_SLT: res = {{(N_BITS-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: err = 1'b1;
        endcase
`ifdef ALU_PIPE_SAT_EN
        // Overflow direction follows the sign of A for both ADD and SUB.
        if (ovf) begin
            res = a_q[MSB] ? SAT_MIN : SAT_MAX;
        end
`endif
        zero = (res == '0);
        neg  = res[MSB];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s0_valid <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            v_q      <= '0;
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else if (advance) begin
            s0_valid <= i_valid;
            if (i_valid) begin
                a_q  <= i_A;
                b_q  <= i_B;
                op_q <= i_Op;
            end
            v_q[0] <= s0_valid;
            d_q[0] <= {res, zero, neg, carry, ovf, err};
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign o_valid = v_q[PIPE_STAGES-1];
    assign {o_res, o_zero, o_neg, o_carry, o_ovf, o_err} = d_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: vector table on PIPE_STAGES=2, plus backpressure,
// mid-flight reset and bubble sequences across PIPE_STAGES=1/2/4.
module tb_alu_pipe;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SLL = 6'b000000;
    localparam logic [5:0] SLT = 6'b101010;
    localparam int NV = 19;

    // flags = {zero, neg, carry, ovf, err}
    typedef struct packed {
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [4:0] flags;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic       in_valid;
    logic       out_ready;

    // index 0: PIPE_STAGES=1, 1: PIPE_STAGES=2, 2: PIPE_STAGES=4
    logic       rdy [3];
    logic [7:0] res [3];
    logic       zf  [3];
    logic       nf  [3];
    logic       cf  [3];
    logic       vf  [3];
    logic       ef  [3];
    logic       vld [3];

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    alu_pipe #(.N_BITS(8), .N_OP(6), .PIPE_STAGES(1)) u_s1 (
        .i_clk(clk), .i_reset(rst), .i_A(a), .i_B(b), .i_Op(op), .i_valid(in_valid),
        .o_ready(rdy[0]), .o_res(res[0]), .o_zero(zf[0]), .o_neg(nf[0]), .o_carry(cf[0]),
        .o_ovf(vf[0]), .o_err(ef[0]), .o_valid(vld[0]), .i_ready(out_ready));

    alu_pipe #(.N_BITS(8), .N_OP(6), .PIPE_STAGES(2)) u_s2 (
        .i_clk(clk), .i_reset(rst), .i_A(a), .i_B(b), .i_Op(op), .i_valid(in_valid),
        .o_ready(rdy[1]), .o_res(res[1]), .o_zero(zf[1]), .o_neg(nf[1]), .o_carry(cf[1]),
        .o_ovf(vf[1]), .o_err(ef[1]), .o_valid(vld[1]), .i_ready(out_ready));

    alu_pipe #(.N_BITS(8), .N_OP(6), .PIPE_STAGES(4)) u_s4 (
        .i_clk(clk), .i_reset(rst), .i_A(a), .i_B(b), .i_Op(op), .i_valid(in_valid),
        .o_ready(rdy[2]), .o_res(res[2]), .o_zero(zf[2]), .o_neg(nf[2]), .o_carry(cf[2]),
        .o_ovf(vf[2]), .o_err(ef[2]), .o_valid(vld[2]), .i_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] bundle(input int d);
        return {vld[d], res[d], zf[d], nf[d], cf[d], vf[d], ef[d]};
    endfunction

    function automatic int stages(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{ADD,   8'h03, 8'h03, 8'h06, 5'b00000};
        vecs[1]  = '{SUB,   8'h06, 8'h02, 8'h04, 5'b00000};
        vecs[2]  = '{SUB,   8'h02, 8'h06, 8'hFC, 5'b01100};
`ifdef ALU_PIPE_SAT_EN
        vecs[3]  = '{ADD,   8'h7F, 8'h01, 8'h7F, 5'b00010};
        vecs[14] = '{SUB,   8'h80, 8'h01, 8'h80, 5'b01010};
        vecs[18] = '{ADD,   8'h80, 8'h80, 8'h80, 5'b01110};
`else
        vecs[3]  = '{ADD,   8'h7F, 8'h01, 8'h80, 5'b01010};
        vecs[14] = '{SUB,   8'h80, 8'h01, 8'h7F, 5'b00010};
        vecs[18] = '{ADD,   8'h80, 8'h80, 8'h00, 5'b10110};
`endif
        vecs[4]  = '{ADD,   8'hFF, 8'h01, 8'h00, 5'b10100};
        vecs[5]  = '{SRA,   8'h8F, 8'h01, 8'hC7, 5'b01000};
        vecs[6]  = '{SRL,   8'h10, 8'h02, 8'h04, 5'b00000};
        vecs[7]  = '{SLL,   8'h01, 8'h09, 8'h02, 5'b00000};
        vecs[8]  = '{NOR,   8'h0F, 8'h04, 8'hF0, 5'b01000};
        vecs[9]  = '{SLT,   8'hFE, 8'h01, 8'h01, 5'b00000};
        vecs[10] = '{6'h3F, 8'h12, 8'h34, 8'h00, 5'b10001};
        vecs[11] = '{AND,   8'hF0, 8'h3C, 8'h30, 5'b00000};
        vecs[12] = '{OR,    8'h0F, 8'h30, 8'h3F, 5'b00000};
        vecs[13] = '{XOR,   8'hFF, 8'h0F, 8'hF0, 5'b01000};
        vecs[15] = '{SUB,   8'h05, 8'h05, 8'h00, 5'b10000};
        vecs[16] = '{SLT,   8'h01, 8'hFE, 8'h00, 5'b10000};
        vecs[17] = '{SRA,   8'h80, 8'h0F, 8'hFF, 5'b01000};

        rst       = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_state_s%0d", stages(d)), {rdy[d], bundle(d)}, {1'b1, 14'h0});
        end
        tick;
        rst = 1'b0;

        // Single ops: nothing at k+1, result at k+2.
        for (int i = 0; i < NV; i++) begin
            op       = vecs[i].op;
            a        = vecs[i].a;
            b        = vecs[i].b;
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            tick;
            check($sformatf("vec%0d_latency", i), {31'b0, vld[1]}, 32'd0);
            tick;
            check($sformatf("vec%0d_result", i), bundle(1), {1'b1, vecs[i].res, vecs[i].flags});
        end
        tick;

        // Back-to-back with three stalled cycles once the first result appears.
        do_reset;
        out_ready = 1'b0;
        op        = ADD;
        for (int i = 1; i <= 3; i++) begin
            a        = 8'(i);
            b        = 8'(i);
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_hold%0d", i), {rdy[1], vld[1], res[1]}, {1'b0, 1'b1, 8'h02});
            if (i < 3) tick;
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", {rdy[1], vld[1], res[1]}, {1'b1, 1'b1, 8'h02});
        tick;
        check("drain_op2", {vld[1], res[1]}, {1'b1, 8'h04});
        tick;
        check("drain_op3", {vld[1], res[1]}, {1'b1, 8'h06});
        tick;
        check("drain_empty", {31'b0, vld[1]}, 32'd0);

        // Asynchronous reset with two ops in flight.
        do_reset;
        op       = ADD;
        a        = 8'h05;
        b        = 8'h05;
        in_valid = 1'b1;
        tick;
        a = 8'h06;
        b = 8'h06;
        tick;
        in_valid = 1'b0;
        tick;
        check("flight_before_reset", {vld[1], res[1]}, {1'b1, 8'h0A});
        #2;
        rst = 1'b1;
        #1;
        check("flight_async_reset", bundle(1), 14'h0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("post_reset_idle%0d", i), {31'b0, vld[1]}, 32'd0);
        end
        a        = 8'h07;
        b        = 8'h07;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        check("post_reset_new_op", bundle(1), {1'b1, 8'h0E, 5'b00000});

        // Bubble pattern 1,0,1 on all three depths; accepts land on edges 1 and 3.
        do_reset;
        op = ADD;
        for (int j = 0; j < 10; j++) begin
            in_valid = (j == 0 || j == 2);
            a        = 8'(j + 1);
            b        = 8'(j + 1);
            tick;
            for (int d = 0; d < 3; d++) begin
                logic ev;
                ev = ((j + 1) == (1 + stages(d))) || ((j + 1) == (3 + stages(d)));
                check($sformatf("bubble_s%0d_edge%0d", stages(d), j + 1), {31'b0, vld[d]}, {31'b0, ev});
                if (ev) begin
                    check($sformatf("bubble_s%0d_res%0d", stages(d), j + 1), {24'b0, res[d]},
                          ((j + 1) == (1 + stages(d))) ? 32'h02 : 32'h06);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
